// File: rtl/game_state_ctl_pkg.sv
// Shared state encodings, counter limits and the hit-test helper for the game sequencer.
// The draw stages decode control_state using these same encodings.
package game_state_ctl_pkg;

  typedef enum logic [2:0] {
    MENU_MODE      = 3'b000,
    GAME_MODE      = 3'b001,
    VICTORY_MODE   = 3'b010,
    GAME_OVER_MODE = 3'b011,
    MULTI_WAIT     = 3'b100
  } game_state_t;

  localparam logic [11:0] CNT_MAX = 12'hFFF;

  // Every edge of the box counts as inside; all compares are unsigned 12-bit.
  function automatic logic in_box(input logic [11:0] x,
                                  input logic [11:0] y,
                                  input logic [11:0] x_min,
                                  input logic [11:0] x_max,
                                  input logic [11:0] y_min,
                                  input logic [11:0] y_max);
    return (x >= x_min) && (x <= x_max) && (y >= y_min) && (y <= y_max);
  endfunction

endpackage

// File: rtl/game_state_ctl_edge_latch.sv
// Rising-edge detector feeding a sticky flag that is cleared on the frame tick.
// An edge arriving on the tick cycle wins over the clear, so it carries into the next frame.
module game_state_ctl_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  input  logic clear,
  output logic flag
);

  logic sig_q;
  logic rise;

  assign rise = sig & ~sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 1'b0;
      flag  <= 1'b0;
    end else begin
      sig_q <= sig;
      if (rise) begin
        flag <= 1'b1;
      end else if (clear) begin
        flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/game_state_ctl.sv
// Top-level game sequencer: turns clicks, menu button, death, survival time and remote readiness
// into control_state changes, applied only on the vblnk rising edge so no frame mixes states.
module game_state_ctl
  import game_state_ctl_pkg::*;
#(
  parameter logic [11:0] PLAY_X_MIN     = 12'd412,
  parameter logic [11:0] PLAY_X_MAX     = 12'd612,
  parameter logic [11:0] PLAY_Y_MIN     = 12'd300,
  parameter logic [11:0] PLAY_Y_MAX     = 12'd380,
  parameter logic [11:0] MULTI_Y_MIN    = 12'd420,
  parameter logic [11:0] MULTI_Y_MAX    = 12'd500,
  parameter logic [11:0] VICTORY_FRAMES = 12'd1800,
  parameter logic [11:0] HOLD_FRAMES    = 12'd30,
  parameter logic [11:0] MULTI_TIMEOUT  = 12'd600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  input  logic        btn_menu,
  input  logic        player_dead,
  input  logic        remote_ready,
  output logic [2:0]  control_state,
  output logic        game_start,
  output logic [11:0] frame_cnt
);

  logic        vblnk_q;
  logic        tick;
  logic        mouse_left_q;
  logic [11:0] click_x;
  logic [11:0] click_y;
  logic        click_flag;
  logic        menu_flag;
  logic        dead_flag;
  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic        click_play;
  logic        click_multi;
  logic        hold_done;

  assign tick          = vblnk_in & ~vblnk_q;
  assign control_state = state_q;

  game_state_ctl_edge_latch u_click_latch (
    .clk   (clk),
    .rst   (rst),
    .sig   (mouse_left),
    .clear (tick),
    .flag  (click_flag)
  );

  game_state_ctl_edge_latch u_menu_latch (
    .clk   (clk),
    .rst   (rst),
    .sig   (btn_menu),
    .clear (tick),
    .flag  (menu_flag)
  );

  game_state_ctl_edge_latch u_dead_latch (
    .clk   (clk),
    .rst   (rst),
    .sig   (player_dead),
    .clear (tick),
    .flag  (dead_flag)
  );

  // The most recent click position is what the next tick judges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_q      <= 1'b0;
      mouse_left_q <= 1'b0;
      click_x      <= '0;
      click_y      <= '0;
    end else begin
      vblnk_q      <= vblnk_in;
      mouse_left_q <= mouse_left;
      if (mouse_left && !mouse_left_q) begin
        click_x <= mouse_xpos;
        click_y <= mouse_ypos;
      end
    end
  end

  assign click_play  = in_box(click_x, click_y, PLAY_X_MIN, PLAY_X_MAX, PLAY_Y_MIN, PLAY_Y_MAX);
  assign click_multi = in_box(click_x, click_y, PLAY_X_MIN, PLAY_X_MAX, MULTI_Y_MIN, MULTI_Y_MAX);
  assign hold_done   = (frame_cnt >= HOLD_FRAMES);

  // Priority within each state: menu button, death, timer, click.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MENU_MODE: begin
        if (tick && !menu_flag && click_flag) begin
          if (click_play) begin
            state_d = GAME_MODE;
          end else if (click_multi) begin
            state_d = MULTI_WAIT;
          end
        end
      end
      GAME_MODE: begin
        if (tick) begin
          if (menu_flag) begin
            state_d = MENU_MODE;
          end else if (dead_flag) begin
            state_d = GAME_OVER_MODE;
          end else if (frame_cnt == VICTORY_FRAMES - 12'd1) begin
            state_d = VICTORY_MODE;
          end
        end
      end
      VICTORY_MODE, GAME_OVER_MODE: begin
        if (tick) begin
          if (menu_flag) begin
            state_d = MENU_MODE;
          end else if (click_flag && hold_done) begin
            state_d = click_play ? GAME_MODE : MENU_MODE;
          end
        end
      end
      MULTI_WAIT: begin
        if (tick) begin
          if (menu_flag) begin
            state_d = MENU_MODE;
          end else if (remote_ready) begin
            state_d = GAME_MODE;
          end else if (frame_cnt == MULTI_TIMEOUT - 12'd1) begin
            state_d = MENU_MODE;
          end
        end
      end
      default: state_d = MENU_MODE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MENU_MODE;
      game_start <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      game_start <= (state_d == GAME_MODE) && (state_q != GAME_MODE);
      if (state_d != state_q) begin
        frame_cnt <= '0;
      end else if (tick && (frame_cnt != CNT_MAX)) begin
        frame_cnt <= frame_cnt + 12'd1;
      end
    end
  end

endmodule

// File: tb/tb_game_state_ctl.sv
// Scoreboard bench for game_state_ctl: expected post-tick outputs are queued as stimulus is
// driven and compared one clock after each vblnk rising edge.
module tb_game_state_ctl;
  import game_state_ctl_pkg::*;

  logic        clk;
  logic        rst;
  logic        vblnk_in;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic        btn_menu;
  logic        player_dead;
  logic        remote_ready;
  logic [2:0]  control_state;
  logic        game_start;
  logic [11:0] frame_cnt;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    string       tag;
    logic [2:0]  state;
    logic        start;
    logic [11:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  game_state_ctl dut (
    .clk           (clk),
    .rst           (rst),
    .vblnk_in      (vblnk_in),
    .mouse_xpos    (mouse_xpos),
    .mouse_ypos    (mouse_ypos),
    .mouse_left    (mouse_left),
    .btn_menu      (btn_menu),
    .player_dead   (player_dead),
    .remote_ready  (remote_ready),
    .control_state (control_state),
    .game_start    (game_start),
    .frame_cnt     (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic expectNext(input string tag, input logic [2:0] st, input logic gs, input logic [11:0] cnt);
    exp_t e;
    e.tag   = tag;
    e.state = st;
    e.start = gs;
    e.cnt   = cnt;
    exp_q.push_back(e);
  endtask

  // One frame: vblnk high for a single clock, optionally with a click on that same cycle.
  task automatic applyStimulus(input logic click_now, input logic [11:0] x, input logic [11:0] y);
    exp_t e;
    @(negedge clk);
    vblnk_in = 1'b1;
    if (click_now) begin
      mouse_xpos = x;
      mouse_ypos = y;
      mouse_left = 1'b1;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({e.tag, "_state"}, 32'(control_state), 32'(e.state));
      checkOutput({e.tag, "_start"}, 32'(game_start), 32'(e.start));
      checkOutput({e.tag, "_cnt"}, 32'(frame_cnt), 32'(e.cnt));
      if (e.start) begin
        @(posedge clk);
        #1;
        checkOutput({e.tag, "_start_pulse_end"}, 32'(game_start), 32'd0);
      end
    end
    @(negedge clk);
    vblnk_in   = 1'b0;
    mouse_left = 1'b0;
  endtask

  task automatic frameTick();
    applyStimulus(1'b0, 12'd0, 12'd0);
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) frameTick();
  endtask

  task automatic clickAt(input logic [11:0] x, input logic [11:0] y);
    @(negedge clk);
    mouse_xpos = x;
    mouse_ypos = y;
    mouse_left = 1'b1;
    @(negedge clk);
    mouse_left = 1'b0;
  endtask

  task automatic pulseMenu();
    @(negedge clk);
    btn_menu = 1'b1;
    @(negedge clk);
    btn_menu = 1'b0;
  endtask

  task automatic pulseDead();
    @(negedge clk);
    player_dead = 1'b1;
    @(negedge clk);
    player_dead = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    vblnk_in     = 1'b0;
    mouse_xpos   = '0;
    mouse_ypos   = '0;
    mouse_left   = 1'b0;
    btn_menu     = 1'b0;
    player_dead  = 1'b0;
    remote_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", 32'(control_state), 32'(MENU_MODE));
    checkOutput("reset_start", 32'(game_start), 32'd0);
    checkOutput("reset_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Click mid-frame must not act before the next vblnk rise.
    clickAt(12'd500, 12'd340);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("menu_wait_tick", 32'(control_state), 32'(MENU_MODE));
    expectNext("menu_play", GAME_MODE, 1'b1, 12'd0);
    frameTick();

    runTicks(500);
    checkOutput("game500_state", 32'(control_state), 32'(GAME_MODE));
    checkOutput("game500_cnt", 32'(frame_cnt), 32'd500);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_state", 32'(control_state), 32'(MENU_MODE));
    checkOutput("async_reset_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Survive to victory, then hold and menu exit.
    clickAt(12'd500, 12'd340);
    expectNext("victory_enter", GAME_MODE, 1'b1, 12'd0);
    frameTick();
    runTicks(1799);
    checkOutput("victory_pre_state", 32'(control_state), 32'(GAME_MODE));
    checkOutput("victory_pre_cnt", 32'(frame_cnt), 32'd1799);
    expectNext("victory", VICTORY_MODE, 1'b0, 12'd0);
    frameTick();
    clickAt(12'd500, 12'd340);
    expectNext("victory_hold_click", VICTORY_MODE, 1'b0, 12'd1);
    frameTick();
    pulseMenu();
    expectNext("victory_menu", MENU_MODE, 1'b0, 12'd0);
    frameTick();

    // Death on the victory tick wins.
    clickAt(12'd500, 12'd340);
    expectNext("death_enter", GAME_MODE, 1'b1, 12'd0);
    frameTick();
    runTicks(1799);
    pulseDead();
    expectNext("death_vs_victory", GAME_OVER_MODE, 1'b0, 12'd0);
    frameTick();

    runTicks(9);
    clickAt(12'd500, 12'd340);
    expectNext("go_tick10", GAME_OVER_MODE, 1'b0, 12'd10);
    frameTick();
    runTicks(19);
    clickAt(12'd500, 12'd340);
    expectNext("go_tick30", GAME_OVER_MODE, 1'b0, 12'd30);
    frameTick();
    clickAt(12'd500, 12'd340);
    expectNext("go_tick31_play", GAME_MODE, 1'b1, 12'd0);
    frameTick();

    pulseDead();
    expectNext("go_again", GAME_OVER_MODE, 1'b0, 12'd0);
    frameTick();
    runTicks(30);
    clickAt(12'd50, 12'd50);
    expectNext("go_click_outside", MENU_MODE, 1'b0, 12'd0);
    frameTick();

    // Box boundaries on the menu.
    clickAt(12'd50, 12'd50);
    expectNext("menu_miss", MENU_MODE, 1'b0, 12'd1);
    frameTick();
    clickAt(12'd613, 12'd340);
    expectNext("menu_x_edge_out", MENU_MODE, 1'b0, 12'd2);
    frameTick();
    clickAt(12'd612, 12'd380);
    expectNext("menu_corner_in", GAME_MODE, 1'b1, 12'd0);
    frameTick();
    pulseMenu();
    expectNext("game_menu", MENU_MODE, 1'b0, 12'd0);
    frameTick();
    clickAt(12'd500, 12'd381);
    expectNext("menu_gap", MENU_MODE, 1'b0, 12'd1);
    frameTick();

    // Multiplayer wait: timeout, then ready.
    clickAt(12'd500, 12'd450);
    expectNext("multi_enter", MULTI_WAIT, 1'b0, 12'd0);
    frameTick();
    runTicks(598);
    expectNext("multi_599", MULTI_WAIT, 1'b0, 12'd599);
    frameTick();
    expectNext("multi_timeout", MENU_MODE, 1'b0, 12'd0);
    frameTick();
    clickAt(12'd412, 12'd420);
    expectNext("multi_corner", MULTI_WAIT, 1'b0, 12'd0);
    frameTick();
    runTicks(4);
    remote_ready = 1'b1;
    expectNext("multi_ready", GAME_MODE, 1'b1, 12'd0);
    frameTick();
    remote_ready = 1'b0;

    // Menu button outranks death in the same frame.
    pulseMenu();
    pulseDead();
    expectNext("menu_over_dead", MENU_MODE, 1'b0, 12'd0);
    frameTick();

    // A click landing on the tick cycle is kept for the following frame.
    expectNext("click_on_tick", MENU_MODE, 1'b0, 12'd1);
    applyStimulus(1'b1, 12'd500, 12'd340);
    expectNext("click_kept", GAME_MODE, 1'b1, 12'd0);
    frameTick();

    // Illegal encoding recovers without a tick.
    @(negedge clk);
    force dut.state_q = 3'b110;
    @(posedge clk);
    #1;
    release dut.state_q;
    @(posedge clk);
    #1;
    checkOutput("illegal_recover_state", 32'(control_state), 32'(MENU_MODE));
    checkOutput("illegal_recover_cnt", 32'(frame_cnt), 32'd0);

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
